decode_ctrl_pipe: RTL and testbench

Registered, handshaked successor to the processor's combinational instruction decoder. It sits between Fetch and Execute, decodes ARM-style DP, memory, branch and multi-cycle (MUL/MLA/UMULL/DIV) instructions into a registered control bundle, and applies valid/ready back-pressure. A built-in sequencer issues multi-cycle operations, waits for completion with a timeout, and sequences one or two register write-backs. Compile-time parameters enable or disable the multi-cycle, long-multiply and divide features.

---
 rtl/decode_ctrl_pipe_if.sv | 46 ++++
 rtl/decode_ctrl_pipe.sv | 199 +++++++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_ctrl_pipe_if.sv
// Fetch/Execute handshake, control bundle and MCycle unit signals of decode_ctrl_pipe.
// The slave modport is the decoder; the master modport is its environment.
interface decode_ctrl_pipe_if;
    logic [31:0] InstrF;
    logic        ValidF;
    logic        ReadyD;
    logic        FlushD;
    logic        ValidE;
    logic        ReadyE;
    logic [31:0] InstrE;
    logic        RegW;
    logic        MemW;
    logic        MemtoReg;
    logic        NoWrite;
    logic        ALUSrc;
    logic        PCS;
    logic [1:0]  ImmSrc;
    logic [2:0]  RegSrc;
    logic [3:0]  ALUControl;
    logic [1:0]  FlagW;
    logic        Undef;
    logic        MCStart;
    logic        MCOp;
    logic        MCAdd;
    logic        MCLong;
    logic        MCDone;
    logic        MCWrite;
    logic [3:0]  WASel;
    logic        MCHi;
    logic        MCErr;
    logic        MCAbort;

    modport master (
        output InstrF, ValidF, FlushD, ReadyE, MCDone,
        input  ReadyD, ValidE, InstrE, RegW, MemW, MemtoReg, NoWrite, ALUSrc, PCS,
               ImmSrc, RegSrc, ALUControl, FlagW, Undef, MCStart, MCOp, MCAdd, MCLong,
               MCWrite, WASel, MCHi, MCErr, MCAbort
    );

    modport slave (
        input  InstrF, ValidF, FlushD, ReadyE, MCDone,
        output ReadyD, ValidE, InstrE, RegW, MemW, MemtoReg, NoWrite, ALUSrc, PCS,
               ImmSrc, RegSrc, ALUControl, FlagW, Undef, MCStart, MCOp, MCAdd, MCLong,
               MCWrite, WASel, MCHi, MCErr, MCAbort
    );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// Registered ARM-style instruction decoder between Fetch and Execute, with a built-in
// sequencer that issues MUL/MLA/UMULL/DIV, waits with a timeout and drives write-back.
module decode_ctrl_pipe #(
    parameter bit          MC_EN      = 1'b1,
    parameter bit          LONG_EN    = 1'b1,
    parameter bit          DIV_EN     = 1'b1,
    parameter int unsigned MC_TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RESETn,
    decode_ctrl_pipe_if.slave bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MC_WAIT  = 2'd1;
    localparam logic [1:0] MC_WB_LO = 2'd2;
    localparam logic [1:0] MC_WB_HI = 2'd3;
    localparam logic [7:0] TIMEOUT  = 8'(MC_TIMEOUT);

    typedef struct packed {
        logic       reg_w;
        logic       mem_w;
        logic       mem_to_reg;
        logic       no_write;
        logic       alu_src;
        logic       pcs;
        logic [1:0] imm_src;
        logic [2:0] reg_src;
        logic [3:0] alu_ctrl;
        logic [1:0] flag_w;
        logic       undef;
    } ctrl_t;

    logic [1:0]  rst_sync;
    logic        rst_n;
    logic [1:0]  state;
    logic [7:0]  cnt;
    logic        vld_p1;
    logic [31:0] instr_p1;
    ctrl_t       ctrl_p1;
    logic        mc_op_p1;
    logic        mc_add_p1;
    logic        mc_long_p1;
    logic [3:0]  wa_lo_p1;
    logic [3:0]  wa_hi_p1;

    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  cmd;
    logic        mul_pat;
    logic        div_pat;
    logic        is_mul;
    logic        is_mla;
    logic        is_umull;
    logic        is_mc;
    logic        logical;
    ctrl_t       dec;
    logic        ready;
    logic        accept;
    logic        mc_write;

    // Reset asserts immediately but is released on a clock edge.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    always_comb begin
        op       = bus.InstrF[27:26];
        funct    = bus.InstrF[25:20];
        cmd      = funct[4:1];
        mul_pat  = (op == 2'b00) && !funct[5] && (bus.InstrF[7:4] == 4'b1001);
        div_pat  = (op == 2'b01) && (funct == 6'b111111) && (bus.InstrF[7:4] == 4'b1111);
        is_mul   = mul_pat && (cmd == 4'b0000);
        is_mla   = mul_pat && (cmd == 4'b0001);
        is_umull = mul_pat && (cmd == 4'b0100);
        is_mc    = MC_EN && (is_mul || is_mla || (LONG_EN && is_umull) || (DIV_EN && div_pat));
        logical  = (cmd[3:1] == 3'b000) || (cmd[3:1] == 3'b100) || (cmd[3:2] == 2'b11);
        dec      = '0;
        case (op)
            2'b00: begin
                // Multiply-pattern encodings never fall through to DP decode.
                if (mul_pat) begin
                    dec.undef = !is_mc;
                end else begin
                    dec.alu_src  = funct[5];
                    dec.alu_ctrl = cmd;
                    dec.no_write = (cmd[3:2] == 2'b10);
                    dec.reg_w    = !dec.no_write;
                    if (funct[0]) dec.flag_w = logical ? 2'b10 : 2'b11;
                end
            end
            2'b01: begin
                if (div_pat) begin
                    dec.undef = !is_mc;
                end else begin
                    dec.alu_src  = !funct[5];
                    dec.imm_src  = 2'b01;
                    dec.alu_ctrl = funct[3] ? 4'b0100 : 4'b0010;
                    if (funct[0]) begin
                        dec.mem_to_reg = 1'b1;
                        dec.reg_w      = 1'b1;
                    end else begin
                        dec.mem_w   = 1'b1;
                        dec.reg_src = 3'b010;
                    end
                end
            end
            2'b10: begin
                dec.alu_src  = 1'b1;
                dec.imm_src  = 2'b10;
                dec.reg_src  = 3'b001;
                dec.alu_ctrl = 4'b0100;
            end
            default: dec.undef = 1'b1;
        endcase
        dec.pcs = ((bus.InstrF[15:12] == 4'hF) && dec.reg_w) || (op == 2'b10);
    end

    assign ready    = (state == IDLE) && (!vld_p1 || bus.ReadyE);
    assign accept   = bus.ValidF && ready && !bus.FlushD;
    assign mc_write = ((state == MC_WB_LO) || (state == MC_WB_HI)) && !bus.FlushD;

    // Stage p1: registered bundle plus multi-cycle sequencer.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            vld_p1     <= 1'b0;
            instr_p1   <= '0;
            ctrl_p1    <= '0;
            mc_op_p1   <= 1'b0;
            mc_add_p1  <= 1'b0;
            mc_long_p1 <= 1'b0;
            wa_lo_p1   <= '0;
            wa_hi_p1   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.FlushD) begin
                        vld_p1 <= 1'b0;
                    end else if (accept && is_mc) begin
                        state      <= MC_WAIT;
                        cnt        <= 8'd1;
                        vld_p1     <= 1'b0;
                        mc_op_p1   <= div_pat;
                        mc_add_p1  <= is_mla;
                        mc_long_p1 <= is_umull;
                        wa_lo_p1   <= (is_mul || is_mla) ? bus.InstrF[19:16] : bus.InstrF[15:12];
                        wa_hi_p1   <= bus.InstrF[19:16];
                    end else if (accept) begin
                        vld_p1   <= 1'b1;
                        instr_p1 <= bus.InstrF;
                        ctrl_p1  <= dec;
                    end else if (bus.ReadyE) begin
                        vld_p1 <= 1'b0;
                    end
                end
                MC_WAIT: begin
                    // Done on the timeout cycle still counts as a completion.
                    if (bus.FlushD)             state <= IDLE;
                    else if (bus.MCDone)        state <= MC_WB_LO;
                    else if (cnt == TIMEOUT)    state <= IDLE;
                    else                        cnt   <= cnt + 8'd1;
                end
                MC_WB_LO: begin
                    if (bus.FlushD)      state <= IDLE;
                    else if (mc_long_p1) state <= MC_WB_HI;
                    else                 state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ReadyD     = ready;
    assign bus.ValidE     = vld_p1;
    assign bus.InstrE     = instr_p1;
    assign bus.RegW       = ctrl_p1.reg_w;
    assign bus.MemW       = ctrl_p1.mem_w;
    assign bus.MemtoReg   = ctrl_p1.mem_to_reg;
    assign bus.NoWrite    = ctrl_p1.no_write;
    assign bus.ALUSrc     = ctrl_p1.alu_src;
    assign bus.PCS        = ctrl_p1.pcs;
    assign bus.ImmSrc     = ctrl_p1.imm_src;
    assign bus.RegSrc     = ctrl_p1.reg_src;
    assign bus.ALUControl = ctrl_p1.alu_ctrl;
    assign bus.FlagW      = ctrl_p1.flag_w;
    assign bus.Undef      = ctrl_p1.undef;
    assign bus.MCStart    = (state == MC_WAIT) && (cnt == 8'd1);
    assign bus.MCOp       = mc_op_p1;
    assign bus.MCAdd      = mc_add_p1;
    assign bus.MCLong     = mc_long_p1;
    assign bus.MCWrite    = mc_write;
    assign bus.MCHi       = mc_write && (state == MC_WB_HI);
    assign bus.WASel      = !mc_write ? 4'd0 : ((state == MC_WB_HI) ? wa_hi_p1 : wa_lo_p1);
    assign bus.MCErr      = (state == MC_WAIT) && !bus.FlushD && !bus.MCDone && (cnt == TIMEOUT);
    assign bus.MCAbort    = bus.FlushD && (state != IDLE);
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: decode table, back-pressure, MC sequencing,
// timeout, flush, mid-sequence reset, and a build with multi-cycle support disabled.
module tb_decode_ctrl_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] I_ADDS  = 32'hE2921005;
    localparam logic [31:0] I_ANDS  = 32'hE0133004;
    localparam logic [31:0] I_MOVPC = 32'hE1A0F000;
    localparam logic [31:0] I_CMP   = 32'hE1510002;
    localparam logic [31:0] I_LDRI  = 32'hE5910004;
    localparam logic [31:0] I_LDRR  = 32'hE7910002;
    localparam logic [31:0] I_STR   = 32'hE5032008;
    localparam logic [31:0] I_B     = 32'hEA000010;
    localparam logic [31:0] I_OP11  = 32'hEE000000;
    localparam logic [31:0] I_UMLAL = 32'hE0A54291;
    localparam logic [31:0] I_MUL   = 32'hE0030291;
    localparam logic [31:0] I_MLA   = 32'hE0267291;
    localparam logic [31:0] I_UMULL = 32'hE0854291;
    localparam logic [31:0] I_DIV   = 32'hE7F18FF2;

    // {RegW,MemW,MemtoReg,NoWrite,ALUSrc,PCS, ImmSrc, RegSrc, ALUControl, FlagW, Undef}
    localparam logic [31:0] DP_INSTR [10] = '{I_ADDS, I_ANDS, I_MOVPC, I_CMP, I_LDRI,
                                              I_LDRR, I_STR, I_B, I_OP11, I_UMLAL};
    localparam logic [17:0] DP_EXP [10] = '{
        18'b100010_00_000_0100_11_0,
        18'b100000_00_000_0000_10_0,
        18'b100001_00_000_1101_00_0,
        18'b000100_00_000_1010_11_0,
        18'b101010_01_000_0100_00_0,
        18'b101000_01_000_0100_00_0,
        18'b010010_01_010_0010_00_0,
        18'b000011_10_001_0100_00_0,
        18'b000000_00_000_0000_00_1,
        18'b000000_00_000_0000_00_1
    };

    decode_ctrl_pipe_if bus();
    decode_ctrl_pipe_if bus_nomc();

    decode_ctrl_pipe #(.MC_EN(1'b1), .LONG_EN(1'b1), .DIV_EN(1'b1), .MC_TIMEOUT(64)) dut (
        .CLK(clk), .RESETn(rst_n), .bus(bus));
    decode_ctrl_pipe #(.MC_EN(1'b0), .LONG_EN(1'b1), .DIV_EN(1'b1), .MC_TIMEOUT(64)) dut_nomc (
        .CLK(clk), .RESETn(rst_n), .bus(bus_nomc));

    always #5 clk = ~clk;

    function automatic logic [17:0] bundle_of();
        return {bus.RegW, bus.MemW, bus.MemtoReg, bus.NoWrite, bus.ALUSrc, bus.PCS,
                bus.ImmSrc, bus.RegSrc, bus.ALUControl, bus.FlagW, bus.Undef};
    endfunction

    function automatic logic [127:0] outs_of();
        return 128'({bus.ValidE, bus.InstrE, bundle_of(), bus.MCStart, bus.MCOp, bus.MCAdd,
                     bus.MCLong, bus.MCWrite, bus.WASel, bus.MCHi, bus.MCErr, bus.MCAbort});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.InstrF = '0; bus.ValidF = 1'b0; bus.FlushD = 1'b0; bus.ReadyE = 1'b1; bus.MCDone = 1'b0;
        bus_nomc.InstrF = '0; bus_nomc.ValidF = 1'b0; bus_nomc.FlushD = 1'b0;
        bus_nomc.ReadyE = 1'b1; bus_nomc.MCDone = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (outs_of() !== 128'd0) begin errors++; $display("FAIL reset_outs: got %h, expected 0", outs_of()); end
        checks++; if (bus.ReadyD !== 1'b1) begin errors++; $display("FAIL reset_readyd: got %b, expected 1", bus.ReadyD); end
        rst_n = 1'b1;
        tick(); tick(); tick();
        checks++; if (outs_of() !== 128'd0) begin errors++; $display("FAIL post_reset_outs: got %h, expected 0", outs_of()); end
    endtask

    task automatic test_decode();
        bus.ReadyE = 1'b1;
        bus.ValidF = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.InstrF = DP_INSTR[i];
            tick();
            checks++; if (bus.ValidE !== 1'b1) begin errors++; $display("FAIL dec_valid[%0d]: got %b, expected 1", i, bus.ValidE); end
            checks++; if (bus.InstrE !== DP_INSTR[i]) begin errors++; $display("FAIL dec_instr[%0d]: got %h, expected %h", i, bus.InstrE, DP_INSTR[i]); end
            checks++; if (bundle_of() !== DP_EXP[i]) begin errors++; $display("FAIL dec_bundle[%0d]: got %b, expected %b", i, bundle_of(), DP_EXP[i]); end
        end
        bus.ValidF = 1'b0;
        tick();
        checks++; if (bus.ValidE !== 1'b0) begin errors++; $display("FAIL dec_drain: got %b, expected 0", bus.ValidE); end
    endtask

    task automatic test_backpressure();
        bus.ReadyE = 1'b0; bus.ValidF = 1'b1; bus.InstrF = I_ADDS;
        tick();
        bus.InstrF = I_ANDS;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.ReadyD !== 1'b0) begin errors++; $display("FAIL bp_readyd[%0d]: got %b, expected 0", c, bus.ReadyD); end
            checks++; if ({bus.ValidE, bus.InstrE, bundle_of()} !== {1'b1, I_ADDS, DP_EXP[0]}) begin
                errors++; $display("FAIL bp_hold[%0d]: got %h, expected %h", c, {bus.ValidE, bus.InstrE, bundle_of()}, {1'b1, I_ADDS, DP_EXP[0]}); end
            tick();
        end
        bus.ReadyE = 1'b1;
        #1;
        checks++; if (bus.ReadyD !== 1'b1) begin errors++; $display("FAIL bp_release: got %b, expected 1", bus.ReadyD); end
        tick();
        checks++; if ({bus.ValidE, bus.InstrE, bundle_of()} !== {1'b1, I_ANDS, DP_EXP[1]}) begin
            errors++; $display("FAIL bp_second: got %h, expected %h", {bus.ValidE, bus.InstrE, bundle_of()}, {1'b1, I_ANDS, DP_EXP[1]}); end
        bus.ValidF = 1'b0;
        tick();
    endtask

    task automatic test_umull();
        int n_start = 0;
        int n_wr = 0;
        bus.ReadyE = 1'b1; bus.ValidF = 1'b1; bus.InstrF = I_UMULL;
        tick();
        bus.ValidF = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) bus.MCDone = 1'b1;
            #1;
            if (bus.MCStart) n_start++;
            if (bus.MCWrite) n_wr++;
            if (k == 1) begin
                checks++; if ({bus.MCOp, bus.MCAdd, bus.MCLong, bus.ValidE, bus.ReadyD} !== 5'b00100) begin
                    errors++; $display("FAIL umull_issue: got %b, expected 00100", {bus.MCOp, bus.MCAdd, bus.MCLong, bus.ValidE, bus.ReadyD}); end
            end
            tick();
        end
        bus.MCDone = 1'b0;
        checks++; if (n_start !== 1) begin errors++; $display("FAIL umull_starts: got %0d, expected 1", n_start); end
        checks++; if (n_wr !== 0) begin errors++; $display("FAIL umull_early_write: got %0d, expected 0", n_wr); end
        checks++; if ({bus.MCWrite, bus.WASel, bus.MCHi} !== {1'b1, 4'd4, 1'b0}) begin
            errors++; $display("FAIL umull_wb_lo: got %b, expected 1_0100_0", {bus.MCWrite, bus.WASel, bus.MCHi}); end
        tick();
        checks++; if ({bus.MCWrite, bus.WASel, bus.MCHi} !== {1'b1, 4'd5, 1'b1}) begin
            errors++; $display("FAIL umull_wb_hi: got %b, expected 1_0101_1", {bus.MCWrite, bus.WASel, bus.MCHi}); end
        tick();
        checks++; if ({bus.MCWrite, bus.ReadyD} !== 2'b01) begin errors++; $display("FAIL umull_idle: got %b, expected 01", {bus.MCWrite, bus.ReadyD}); end
    endtask

    task automatic test_mul_short();
        bus.ValidF = 1'b1; bus.InstrF = I_MUL;
        tick();
        bus.ValidF = 1'b0; bus.MCDone = 1'b1;
        #1;
        checks++; if ({bus.MCStart, bus.MCErr, bus.MCLong} !== 3'b100) begin
            errors++; $display("FAIL mul_start: got %b, expected 100", {bus.MCStart, bus.MCErr, bus.MCLong}); end
        tick();
        bus.MCDone = 1'b0;
        checks++; if ({bus.MCWrite, bus.WASel, bus.MCHi} !== {1'b1, 4'd3, 1'b0}) begin
            errors++; $display("FAIL mul_wb: got %b, expected 1_0011_0", {bus.MCWrite, bus.WASel, bus.MCHi}); end
        tick();
        checks++; if ({bus.MCWrite, bus.ReadyD} !== 2'b01) begin errors++; $display("FAIL mul_idle: got %b, expected 01", {bus.MCWrite, bus.ReadyD}); end
    endtask

    task automatic test_timeout(input bit done_at_limit);
        int n_err = 0;
        int n_wr = 0;
        int err_k = 0;
        bus.ValidF = 1'b1; bus.InstrF = I_DIV;
        tick();
        bus.ValidF = 1'b0;
        checks++; if (bus.MCOp !== 1'b1) begin errors++; $display("FAIL div_mcop: got %b, expected 1", bus.MCOp); end
        for (int k = 1; k <= 64; k++) begin
            if (k == 64 && done_at_limit) bus.MCDone = 1'b1;
            #1;
            if (bus.MCErr) begin n_err++; err_k = k; end
            if (bus.MCWrite) n_wr++;
            tick();
        end
        bus.MCDone = 1'b0;
        if (!done_at_limit) begin
            checks++; if (n_err !== 1 || err_k !== 64) begin errors++; $display("FAIL timeout_err: got %0d pulses at %0d, expected 1 at 64", n_err, err_k); end
            checks++; if (n_wr !== 0 || bus.MCWrite !== 1'b0) begin errors++; $display("FAIL timeout_nowrite: got %0d writes, expected 0", n_wr); end
            checks++; if ({bus.ReadyD, bus.MCErr} !== 2'b10) begin errors++; $display("FAIL timeout_idle: got %b, expected 10", {bus.ReadyD, bus.MCErr}); end
        end else begin
            checks++; if (n_err !== 0) begin errors++; $display("FAIL done_at_limit_err: got %0d, expected 0", n_err); end
            checks++; if ({bus.MCWrite, bus.WASel, bus.MCHi} !== {1'b1, 4'd8, 1'b0}) begin
                errors++; $display("FAIL done_at_limit_wb: got %b, expected 1_1000_0", {bus.MCWrite, bus.WASel, bus.MCHi}); end
            tick();
            checks++; if (bus.MCWrite !== 1'b0) begin errors++; $display("FAIL done_at_limit_single: got %b, expected 0", bus.MCWrite); end
        end
    endtask

    task automatic test_flush();
        int n_wr = 0;
        bus.ValidF = 1'b1; bus.InstrF = I_MLA;
        tick();
        bus.ValidF = 1'b0;
        checks++; if (bus.MCAdd !== 1'b1) begin errors++; $display("FAIL mla_mcadd: got %b, expected 1", bus.MCAdd); end
        tick(); tick();
        bus.FlushD = 1'b1;
        #1;
        checks++; if ({bus.MCAbort, bus.MCWrite} !== 2'b10) begin errors++; $display("FAIL flush_abort: got %b, expected 10", {bus.MCAbort, bus.MCWrite}); end
        tick();
        bus.FlushD = 1'b0; bus.MCDone = 1'b1;
        #1;
        checks++; if ({bus.MCAbort, bus.ReadyD} !== 2'b01) begin errors++; $display("FAIL flush_idle: got %b, expected 01", {bus.MCAbort, bus.ReadyD}); end
        for (int c = 0; c < 3; c++) begin
            if (bus.MCWrite) n_wr++;
            tick();
        end
        bus.MCDone = 1'b0;
        checks++; if (n_wr !== 0) begin errors++; $display("FAIL flush_nowrite: got %0d, expected 0", n_wr); end
        // Flush in IDLE kills the held bundle and drops the concurrent fetch.
        bus.ValidF = 1'b1; bus.InstrF = I_ADDS; bus.ReadyE = 1'b1;
        tick();
        bus.ReadyE = 1'b0; bus.FlushD = 1'b1; bus.InstrF = I_ANDS;
        tick();
        bus.FlushD = 1'b0; bus.ValidF = 1'b0; bus.ReadyE = 1'b1;
        #1;
        checks++; if ({bus.ValidE, bus.ReadyD} !== 2'b01) begin errors++; $display("FAIL flush_idle_kill: got %b, expected 01", {bus.ValidE, bus.ReadyD}); end
    endtask

    task automatic test_reset_mid_mc();
        int n_wr = 0;
        bus.ValidF = 1'b1; bus.InstrF = I_MLA;
        tick();
        bus.ValidF = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        checks++; if (outs_of() !== 128'd0) begin errors++; $display("FAIL midreset_outs: got %h, expected 0", outs_of()); end
        checks++; if (bus.ReadyD !== 1'b1) begin errors++; $display("FAIL midreset_readyd: got %b, expected 1", bus.ReadyD); end
        bus.MCDone = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (bus.MCWrite) n_wr++;
            tick();
        end
        bus.MCDone = 1'b0;
        checks++; if (n_wr !== 0) begin errors++; $display("FAIL midreset_nowrite: got %0d, expected 0", n_wr); end
        checks++; if (outs_of() !== 128'd0) begin errors++; $display("FAIL midreset_after: got %h, expected 0", outs_of()); end
    endtask

    task automatic test_no_mc();
        bus_nomc.ReadyE = 1'b1; bus_nomc.ValidF = 1'b1; bus_nomc.InstrF = I_MUL;
        tick();
        checks++; if ({bus_nomc.ValidE, bus_nomc.Undef, bus_nomc.RegW, bus_nomc.MCStart} !== 4'b1100) begin
            errors++; $display("FAIL nomc_mul: got %b, expected 1100", {bus_nomc.ValidE, bus_nomc.Undef, bus_nomc.RegW, bus_nomc.MCStart}); end
        bus_nomc.InstrF = I_DIV;
        tick();
        checks++; if ({bus_nomc.ValidE, bus_nomc.Undef, bus_nomc.MemtoReg, bus_nomc.MCStart} !== 4'b1100) begin
            errors++; $display("FAIL nomc_div: got %b, expected 1100", {bus_nomc.ValidE, bus_nomc.Undef, bus_nomc.MemtoReg, bus_nomc.MCStart}); end
        bus_nomc.ValidF = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_umull();
        test_mul_short();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_flush();
        test_reset_mid_mc();
        test_no_mc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
